// File: rtl/mp_subtractor_serial_if.sv
// Limb-stream bundle for the serial multi-precision subtractor.
// master drives operands, start and downstream ready; slave is the subtractor.
// Ports: iStart/iC start an op; iA/iB/iValid/oReady carry limbs in;
//        oDiff/oValid/iReady/oLast carry limbs out; oBorrow/oBusy/oDone report status.
interface mp_subtractor_serial_if #(
    parameter int LIMB_WIDTH = 8
);
    logic                  iStart;
    logic                  iC;
    logic [LIMB_WIDTH-1:0] iA;
    logic [LIMB_WIDTH-1:0] iB;
    logic                  iValid;
    logic                  oReady;
    logic [LIMB_WIDTH-1:0] oDiff;
    logic                  oValid;
    logic                  iReady;
    logic                  oLast;
    logic                  oBorrow;
    logic                  oBusy;
    logic                  oDone;

    modport master (
        output iStart, iC, iA, iB, iValid, iReady,
        input  oReady, oDiff, oValid, oLast, oBorrow, oBusy, oDone
    );

    modport slave (
        input  iStart, iC, iA, iB, iValid, iReady,
        output oReady, oDiff, oValid, oLast, oBorrow, oBusy, oDone
    );
endinterface

// File: rtl/mp_subtractor_serial.sv
// Serial multi-precision subtractor: A - B - iC processed one limb per beat, LS limb first.
// Latency: each accepted limb appears on oDiff one cycle after acceptance; oDone one cycle after last limb consumed.
// Backpressure: single output register; oReady = !oValid || iReady in RUN, so full throughput with no bubble.
// Ports: iClk/iRst (async active-high) plus bus (slave modport of mp_subtractor_serial_if).
module mp_subtractor_serial #(
    parameter int LIMB_WIDTH = 8,
    parameter int NUM_LIMBS  = 4
) (
    input  logic                   iClk,
    input  logic                   iRst,
    mp_subtractor_serial_if.slave  bus
);
    localparam int CW = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_LIMBS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CW-1:0]         cnt;
    logic                  borrow;
    logic [LIMB_WIDTH-1:0] diff_q;
    logic                  vld_q;
    logic                  last_q;
    logic                  borrow_out_q;
    logic                  done_q;
    logic                  ready;
    logic                  accept;
    logic                  consume;
    logic                  last_limb;
    logic [LIMB_WIDTH:0]   sub_full;

    // One extra bit catches the borrow-out: it is set exactly when iA < iB + borrow.
    assign sub_full  = {1'b0, bus.iA} - {1'b0, bus.iB} - {{LIMB_WIDTH{1'b0}}, borrow};
    assign last_limb = (cnt == LAST_IDX);
    assign accept    = bus.iValid && ready;
    assign consume   = vld_q && bus.iReady;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.iStart) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                ready = !vld_q || bus.iReady;
                if (bus.iValid && ready && last_limb) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (vld_q && bus.iReady) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            cnt          <= '0;
            borrow       <= 1'b0;
            diff_q       <= '0;
            vld_q        <= 1'b0;
            last_q       <= 1'b0;
            borrow_out_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.iStart) begin
                        borrow <= bus.iC;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        // A new limb overwrites the register even if the old one is consumed this cycle.
                        diff_q <= sub_full[LIMB_WIDTH-1:0];
                        borrow <= sub_full[LIMB_WIDTH];
                        vld_q  <= 1'b1;
                        last_q <= last_limb;
                        if (!last_limb) begin
                            cnt <= cnt + CW'(1);
                        end
                    end else if (consume) begin
                        vld_q  <= 1'b0;
                        last_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (consume) begin
                        vld_q        <= 1'b0;
                        last_q       <= 1'b0;
                        borrow_out_q <= borrow;
                        done_q       <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.oReady  = ready;
    assign bus.oDiff   = diff_q;
    assign bus.oValid  = vld_q;
    assign bus.oLast   = last_q;
    assign bus.oBorrow = borrow_out_q;
    assign bus.oBusy   = (state != IDLE);
    assign bus.oDone   = done_q;
endmodule

// File: tb/tb_mp_subtractor_serial.sv
// Directed self-checking bench for mp_subtractor_serial (8-bit limbs, 4 limbs).
module tb_mp_subtractor_serial;
    localparam int LW = 8;
    localparam int NL = 4;

    logic iClk = 1'b0;
    logic iRst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 iClk = ~iClk;

    mp_subtractor_serial_if #(.LIMB_WIDTH(LW)) bus ();

    mp_subtractor_serial #(.LIMB_WIDTH(LW), .NUM_LIMBS(NL)) dut (
        .iClk (iClk),
        .iRst (iRst),
        .bus  (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one operation with limbs presented back to back; optional stall after
    // limb 1, optional stray iStart mid-run, optional early exit after abort_at accepts.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic c, input logic [31:0] exp, input logic expb,
                         input bit stall, input bit glitch, input int abort_at);
        int sent       = 0;
        int got        = 0;
        int stall_left = 3;
        int done_cnt   = 0;
        int post       = 0;
        @(negedge iClk);
        bus.iStart = 1'b1;
        bus.iC     = c;
        bus.iValid = 1'b1;
        bus.iA     = 8'hAA;
        bus.iB     = 8'h55;
        bus.iReady = 1'b1;
        #1;
        chk({tag, " idle oReady"}, 32'(bus.oReady), 32'(0));
        chk({tag, " idle oBusy"}, 32'(bus.oBusy), 32'(0));
        for (int cyc = 0; cyc < 40 && post < 2; cyc++) begin
            @(negedge iClk);
            bus.iStart = glitch && (sent == 1);
            bus.iC     = !c;
            bus.iValid = (sent < NL);
            bus.iA     = 8'(a >> (8 * sent));
            bus.iB     = 8'(b >> (8 * sent));
            bus.iReady = 1'b1;
            if (stall && got == 1 && stall_left > 0) begin
                bus.iReady = 1'b0;
                stall_left--;
            end
            #1;
            if (!bus.iReady) begin
                chk({tag, " stall oDiff"}, 32'(bus.oDiff), 32'(8'(exp >> 8)));
                chk({tag, " stall oReady"}, 32'(bus.oReady), 32'(0));
                chk({tag, " stall oValid"}, 32'(bus.oValid), 32'(1));
            end
            if (bus.oValid && bus.iReady) begin
                chk($sformatf("%s limb%0d", tag, got), 32'(bus.oDiff), 32'(8'(exp >> (8 * got))));
                chk($sformatf("%s last%0d", tag, got), 32'(bus.oLast), 32'(got == NL - 1));
                got++;
            end
            if (bus.iValid && bus.oReady) begin
                sent++;
                if (abort_at != 0 && sent == abort_at) return;
            end
            if (bus.oDone) begin
                done_cnt++;
                chk({tag, " oBorrow"}, 32'(bus.oBorrow), 32'(expb));
            end
            if (done_cnt > 0) post++;
        end
        chk({tag, " limbs delivered"}, 32'(got), 32'(NL));
        chk({tag, " done pulses"}, 32'(done_cnt), 32'(1));
        chk({tag, " oBorrow held"}, 32'(bus.oBorrow), 32'(expb));
        chk({tag, " oBusy after"}, 32'(bus.oBusy), 32'(0));
        bus.iValid = 1'b0;
    endtask

    initial begin
        iRst       = 1'b1;
        bus.iStart = 1'b0;
        bus.iC     = 1'b0;
        bus.iA     = '0;
        bus.iB     = '0;
        bus.iValid = 1'b0;
        bus.iReady = 1'b0;
        #2;
        chk("rst oDiff", 32'(bus.oDiff), 32'(0));
        chk("rst oValid", 32'(bus.oValid), 32'(0));
        chk("rst oReady", 32'(bus.oReady), 32'(0));
        chk("rst oBusy", 32'(bus.oBusy), 32'(0));
        chk("rst oDone", 32'(bus.oDone), 32'(0));
        @(negedge iClk);
        @(negedge iClk);
        iRst = 1'b0;

        // 1 - 2 underflows through every limb.
        do_op("underflow", 32'h00000001, 32'h00000002, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 0);
        // No borrows anywhere.
        do_op("plain", 32'h12345678, 32'h02040608, 1'b0, 32'h10305070, 1'b0, 1'b0, 1'b0, 0);
        // Borrow-in alone ripples through all limbs.
        do_op("borrow_in", 32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 0);

        // Abort after two accepted limbs; oBorrow was 1 from the previous op.
        do_op("abort", 32'h12345678, 32'h02040608, 1'b0, 32'h10305070, 1'b0, 1'b0, 1'b0, 2);
        iRst = 1'b1;
        #1;
        chk("mid rst oDiff", 32'(bus.oDiff), 32'(0));
        chk("mid rst oValid", 32'(bus.oValid), 32'(0));
        chk("mid rst oLast", 32'(bus.oLast), 32'(0));
        chk("mid rst oReady", 32'(bus.oReady), 32'(0));
        chk("mid rst oBorrow", 32'(bus.oBorrow), 32'(0));
        chk("mid rst oBusy", 32'(bus.oBusy), 32'(0));
        chk("mid rst oDone", 32'(bus.oDone), 32'(0));
        @(negedge iClk);
        iRst       = 1'b0;
        bus.iValid = 1'b0;
        do_op("after_rst", 32'h12345678, 32'h02040608, 1'b0, 32'h10305070, 1'b0, 1'b0, 1'b0, 0);

        // Backpressure: 0x00010000 - 1 = 0x0000FFFF, limbs FF,FF,00,00.
        do_op("stall", 32'h00010000, 32'h00000001, 1'b0, 32'h0000FFFF, 1'b0, 1'b1, 1'b0, 0);

        // Stray iStart with iC=1 during RUN must not alter the borrow chain.
        do_op("restart", 32'h12345678, 32'h02040608, 1'b0, 32'h10305070, 1'b0, 1'b0, 1'b1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
